imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder serving the fetch stage's PC-driven read requests.
//   Program image is streamed in via a valid/ready load port (testbench or boot loader), then served.
//   Sits between the loader and the fetch stage; replaces the fetch stage's test-only instruction input.
//   Synchronous read, 1-cycle latency; honours fetch stall (rd_en low) by holding its output.
// PARAMETERS
//   ADDR_WIDTH  32    byte-address width of raddr
//   DATA_WIDTH  32    instruction word width
//   DEPTH       256   number of words; power of two, >= 2
// PORTS
//   clk          in   1           single clock, rising edge
//   rst          in   1           asynchronous, active-high reset
//   load_valid   in   1           loader beat valid
//   load_ready   out  1           responder accepts beat
//   load_data    in   DATA_WIDTH  instruction word to store
//   load_last    in   1           final beat of image
//   reload       in   1           pulse: discard image, return to IDLE
//   rd_en        in   1           fetch advancing (driven by PC write enable)
//   raddr        in   ADDR_WIDTH  fetch PC (byte address)
//   ins_o        out  DATA_WIDTH  instruction for raddr of the previous enabled cycle
//   ins_valid    out  1           ins_o holds a served word
//   busy         out  1           image not ready (IDLE or LOAD)
//   misalign_err out  1           sticky: enabled read with raddr[1:0] != 0
// BEHAVIOUR
//   Reset: state=IDLE, wptr=0, load_ready=1, ins_o=NOP (32'h0000_0013), ins_valid=0, busy=1, misalign_err=0.
//     Memory array is not reset. Reset mid-load aborts the image; a new load must start from word 0.
//   FSM IDLE: load_ready=1; beat accepted (load_valid & load_ready) writes mem[0], wptr=1, ->LOAD.
//     A first beat with load_last=1 goes directly to RUN.
//   FSM LOAD: each accepted beat writes mem[wptr], wptr++.
//     load_last=1, or wptr==DEPTH-1 on acceptance -> RUN.
//     Beats beyond DEPTH cannot occur: load_ready=0 in RUN.
//   FSM RUN: load_ready=0, busy=0; load_valid ignored.
//   reload=1 in any state -> IDLE next cycle, wptr=0, ins_valid=0, ins_o=NOP; reload beats load in the same cycle.
//   Read (RUN only): index = raddr[log2(DEPTH)+1:2].
//     rd_en=1 -> next cycle ins_o=mem[index], ins_valid=1.
//     rd_en=0 -> ins_o, ins_valid hold (stall).
//     Index >= wptr (word never loaded) -> ins_o=NOP, ins_valid=1.
//     raddr bits above the index range are ignored (wrap-around).
//   Misaligned (rd_en & raddr[1:0]!=0 in RUN): ins_o=NOP, misalign_err set; cleared only by rst or reload.
//   In IDLE/LOAD, rd_en is ignored: ins_o=NOP, ins_valid=0.
//   Write and read never alias: reads occur only in RUN, writes only in IDLE/LOAD.
// CONFIGURATION
//   IMEM_PARITY_EN defined: each word stores an even-parity bit computed at load.
//     On read, a mismatch drives ins_o=NOP and sets sticky output parity_err (1 bit); parity_err is cleared by rst or reload.
//   IMEM_PARITY_EN undefined: no parity storage; parity_err port absent.
// STRUCTURE
//   Shared package imem_pkg: NOP_INSN constant; state enum {IDLE, LOAD, RUN}; index-width function (clog2 of DEPTH).
//   One sub-module imem_array: DEPTH x (DATA_WIDTH[+1]) single-write, single-read synchronous RAM.
//     The FSM, pointer, error flags and output register stay in imem_responder.
// TESTING
//   1. Reset, then load 4 words 0xA0..A3 (last on 4th beat) -> busy falls after 4th accept.
//      Then rd_en=1, raddr=0x8 -> next cycle ins_o=0xA2, ins_valid=1.
//   2. Load while toggling load_valid with gaps; backpressure check: load_ready=0 once in RUN.
//   3. Stall: raddr=0x4 with rd_en=1, then rd_en=0 with raddr=0xC for 3 cycles -> ins_o holds word 1.
//   4. Read unloaded/out-of-range: raddr=0x40 after a 4-word load -> ins_o=0x0000_0013.
//      raddr=DEPTH*4 -> reads word 0.
//   5. raddr=0x6 with rd_en=1 -> ins_o=NOP and misalign_err=1 until reload; reload mid-RUN -> busy=1, ins_valid=0.
//   6. Reset asserted during LOAD after 2 beats -> state IDLE, load_ready=1.
//      Reload 3 words -> reads correct; (IMEM_PARITY_EN) forced bit flip -> parity_err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   NOP_INSN : word served when there is no valid instruction (addi x0,x0,0)
//   state_t  : responder FSM states
//   idx_w()  : word-index width for a given depth
package imem_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-write, single-read synchronous RAM backing the instruction memory.
// Contents are never reset. The read register only updates when re is high,
// so the last read word is held across fetch stalls.
// Ports:
//   clk         clock
//   we/waddr/wdata  write port
//   re/raddr    read enable / word index
//   rdata       registered read data
module imem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int IW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a program image on a valid/ready
// load port, then serves fetch reads with one cycle of latency.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, parity_err port).
// Ports:
//   clk, rst                       clock, async active-high reset
//   load_valid/ready/data/last     image load stream
//   reload                         discard image, back to IDLE
//   rd_en, raddr                   fetch request (byte address)
//   ins_o, ins_valid               served instruction
//   busy                           image not ready
//   misalign_err                   sticky misaligned-read flag
//   parity_err                     sticky parity flag (IMEM_PARITY_EN only)
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  reload,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] ins_o,
  output logic                  ins_valid,
  output logic                  busy,
  output logic                  misalign_err
`ifdef IMEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int IW = idx_w(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int RW = DATA_WIDTH + 1;
`else
  localparam int RW = DATA_WIDTH;
`endif
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSN);

  state_t          state, state_nx;
  logic [IW:0]     wptr;      // one extra bit: counts up to DEPTH loaded words
  logic            nop_q;     // served word must be replaced by NOP
  logic [RW-1:0]   wdata, rdata;

  // reload wins over a load beat in the same cycle
  wire accept   = load_valid & load_ready & ~reload;
  wire rd_go    = rd_en & (state == RUN) & ~reload;
  wire [IW-1:0] ridx = raddr[IW+1:2];
  wire misal    = |raddr[1:0];
  wire unloaded = {1'b0, ridx} >= wptr;

  // high address bits are deliberately ignored (index wraps)
  wire unused_raddr = ^raddr[ADDR_WIDTH-1:IW+2];

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    if (reload) state_nx = IDLE;
    else begin
      case (state)
        IDLE: if (accept) state_nx = load_last ? RUN : LOAD;
        LOAD: if (accept && (load_last || wptr == (IW+1)'(DEPTH-1))) state_nx = RUN;
        default: state_nx = state;
      endcase
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    load_ready = (state != RUN);
    busy       = (state != RUN);
  end

  // ---- write pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wptr <= '0;
    else if (reload) wptr <= '0;
    else if (accept) wptr <= wptr + 1'b1;
  end

  // ---- read-side flags; RAM read register holds data across stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nop_q        <= 1'b1;
      ins_valid    <= 1'b0;
      misalign_err <= 1'b0;
    end else if (reload || state != RUN) begin
      nop_q     <= 1'b1;
      ins_valid <= 1'b0;
      if (reload) misalign_err <= 1'b0;
    end else if (rd_go) begin
      ins_valid <= 1'b1;
      nop_q     <= misal | unloaded;
      if (misal) misalign_err <= 1'b1;
    end
  end

`ifdef IMEM_PARITY_EN
  // even parity: stored bit makes the whole stored word XOR to zero
  assign wdata = {^load_data, load_data};
  wire par_bad = ins_valid & ~nop_q & (^rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          parity_err <= 1'b0;
    else if (reload)  parity_err <= 1'b0;
    else if (par_bad) parity_err <= 1'b1;
  end

  assign ins_o = (nop_q | par_bad) ? NOP : rdata[DATA_WIDTH-1:0];
`else
  assign wdata = load_data;
  assign ins_o = nop_q ? NOP : rdata;
`endif

  imem_array #(.DEPTH(DEPTH), .WIDTH(RW), .IW(IW)) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr[IW-1:0]),
    .wdata (wdata),
    .re    (rd_go),
    .raddr (ridx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] ins_o;
  logic        ins_valid;
  logic        busy;
  logic        misalign_err;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .reload       (reload),
    .rd_en        (rd_en),
    .raddr        (raddr),
    .ins_o        (ins_o),
    .ins_valid    (ins_valid),
    .busy         (busy),
    .misalign_err (misalign_err)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // all drive helpers start and end on a falling edge
  task automatic beat(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    rd_en = 1'b1; raddr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic load4_a();
    pulse_reload();
    beat(32'hA0, 1'b0); beat(32'hA1, 1'b0); beat(32'hA2, 1'b0); beat(32'hA3, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    n_cmp++; if (ins_o !== NOP)       begin n_bad++; $display("FAIL reset_ins got=%h exp=%h", ins_o, NOP); end
    n_cmp++; if (ins_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid got=%b exp=0", ins_valid); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_misal got=%b exp=0", misalign_err); end
  endtask

  task automatic test_load_read();
    beat(32'hA0, 1'b0); beat(32'hA1, 1'b0); beat(32'hA2, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load3_busy got=%b exp=1", busy); end
    beat(32'hA3, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL load4_busy got=%b exp=0", busy); end
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL run_novalid got=%b exp=0", ins_valid); end
    rd(32'h8);
    n_cmp++; if (ins_o !== 32'hA2)   begin n_bad++; $display("FAIL read_w2 got=%h exp=000000a2", ins_o); end
    n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL read_w2_valid got=%b exp=1", ins_valid); end
  endtask

  task automatic test_gaps();
    pulse_reload();
    n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL reload_busy got=%b exp=1", busy); end
    n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reload_valid got=%b exp=0", ins_valid); end
    beat(32'hB0, 1'b0);
    @(negedge clk);
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL gap_ready got=%b exp=1", load_ready); end
    beat(32'hB1, 1'b0);
    repeat (2) @(negedge clk);
    beat(32'hB2, 1'b1);
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL run_ready got=%b exp=0", load_ready); end
    // beat offered in RUN must be ignored
    beat(32'hDEAD, 1'b0);
    rd(32'h0);
    n_cmp++; if (ins_o !== 32'hB0) begin n_bad++; $display("FAIL gap_w0 got=%h exp=000000b0", ins_o); end
    rd(32'h4);
    n_cmp++; if (ins_o !== 32'hB1) begin n_bad++; $display("FAIL gap_w1 got=%h exp=000000b1", ins_o); end
    rd(32'hC);
    n_cmp++; if (ins_o !== NOP) begin n_bad++; $display("FAIL gap_w3_unloaded got=%h exp=%h", ins_o, NOP); end
    n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL gap_w3_valid got=%b exp=1", ins_valid); end
  endtask

  task automatic test_stall();
    load4_a();
    rd_en = 1'b1; raddr = 32'h4;
    @(negedge clk);
    rd_en = 1'b0; raddr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ins_o !== 32'hA1) begin n_bad++; $display("FAIL stall_hold%0d got=%h exp=000000a1", i, ins_o); end
      n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid%0d got=%b exp=1", i, ins_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_oob();
    rd(32'h40);
    n_cmp++; if (ins_o !== NOP) begin n_bad++; $display("FAIL oob_40 got=%h exp=%h", ins_o, NOP); end
    rd(32'h3FC);
    n_cmp++; if (ins_o !== NOP) begin n_bad++; $display("FAIL oob_last got=%h exp=%h", ins_o, NOP); end
    rd(DEPTH * 4);
    n_cmp++; if (ins_o !== 32'hA0) begin n_bad++; $display("FAIL wrap_w0 got=%h exp=000000a0", ins_o); end
    rd(32'hF00C);
    n_cmp++; if (ins_o !== 32'hA3) begin n_bad++; $display("FAIL wrap_w3 got=%h exp=000000a3", ins_o); end
  endtask

  task automatic test_misalign_reload();
    rd(32'h6);
    n_cmp++; if (ins_o !== NOP)         begin n_bad++; $display("FAIL misal_ins got=%h exp=%h", ins_o, NOP); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL misal_flag got=%b exp=1", misalign_err); end
    rd(32'h0);
    n_cmp++; if (ins_o !== 32'hA0)      begin n_bad++; $display("FAIL after_misal got=%h exp=000000a0", ins_o); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL misal_sticky got=%b exp=1", misalign_err); end
    pulse_reload();
    n_cmp++; if (busy !== 1'b1)         begin n_bad++; $display("FAIL rl_busy got=%b exp=1", busy); end
    n_cmp++; if (ins_valid !== 1'b0)    begin n_bad++; $display("FAIL rl_valid got=%b exp=0", ins_valid); end
    n_cmp++; if (ins_o !== NOP)         begin n_bad++; $display("FAIL rl_ins got=%h exp=%h", ins_o, NOP); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL rl_misal got=%b exp=0", misalign_err); end
    // reads are ignored outside RUN
    rd(32'h0);
    n_cmp++; if (ins_valid !== 1'b0)    begin n_bad++; $display("FAIL idle_read_valid got=%b exp=0", ins_valid); end
  endtask

  task automatic test_reset_mid_load();
    beat(32'hC0, 1'b0); beat(32'hC1, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b exp=1", load_ready); end
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    @(negedge clk);
    rst = 1'b0;
    beat(32'hD0, 1'b0); beat(32'hD1, 1'b0); beat(32'hD2, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL d_busy got=%b exp=0", busy); end
    rd(32'h0);
    n_cmp++; if (ins_o !== 32'hD0) begin n_bad++; $display("FAIL d_w0 got=%h exp=000000d0", ins_o); end
    rd(32'h4);
    n_cmp++; if (ins_o !== 32'hD1) begin n_bad++; $display("FAIL d_w1 got=%h exp=000000d1", ins_o); end
    rd(32'h8);
    n_cmp++; if (ins_o !== 32'hD2) begin n_bad++; $display("FAIL d_w2 got=%h exp=000000d2", ins_o); end
    rd(32'hC);
    n_cmp++; if (ins_o !== NOP)    begin n_bad++; $display("FAIL d_w3 got=%h exp=%h", ins_o, NOP); end
`ifdef IMEM_PARITY_EN
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_clean got=%b exp=0", parity_err); end
    dut.u_array.mem[1][0] = ~dut.u_array.mem[1][0];
    rd(32'h4);
    n_cmp++; if (ins_o !== NOP)       begin n_bad++; $display("FAIL par_ins got=%h exp=%h", ins_o, NOP); end
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_flag got=%b exp=1", parity_err); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_read();
    test_gaps();
    test_stall();
    test_oob();
    test_misalign_reload();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
